// File: rtl/icache_assoc_pkg.sv
// Shared types and address-split helpers for the set-associative
// instruction cache.
//   icache_state_t : controller states (IDLE, FILL, FLUSH)
//   sel_w()        : width of a select/counter field for n items (at least 1)
//   off_w()        : address bits consumed by n items (0 when n == 1)
//   tag_w()        : tag width left over after byte, word and index bits
package icache_assoc_pkg;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} icache_state_t;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned off_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  function automatic int unsigned tag_w(input int unsigned sets, input int unsigned words);
    return WORD_W - BYTE_OFF_W - off_w(words) - off_w(sets);
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Bus bundle for the instruction cache.
//   Datapath side : imemREN, imemaddr, iflush -> cache; ihit, imemload, flushing <- cache
//   Memory side   : iREN, iaddr <- cache; iwait, iload -> cache
// slave  : the cache's view
// master : the environment's view (datapath fetch unit plus memory controller)
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        flushing;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, flushing, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, flushing, iREN, iaddr
  );
endinterface

// File: rtl/icache_assoc_set.sv
// One cache set: WAYS lines of {valid, tag, WORDS x 32-bit data}, plus the
// round-robin replacement pointer.
//   CLK, nRST          : clock, async active-low reset (valid bits, pointer)
//   lk_tag, lk_word    : lookup tag and word offset
//   hit, rdata         : lookup result (rdata meaningful only when hit)
//   victim             : lowest invalid way, else the round-robin way
//   wr_en/way/word/data: fill beat write
//   commit, wr_tag     : last beat; mark line valid with wr_tag
//   clr                : invalidate every way and rewind the pointer
module icache_assoc_set
  import icache_assoc_pkg::*;
#(
  parameter  int unsigned WAYS  = 2,
  parameter  int unsigned WORDS = 2,
  parameter  int unsigned TAG_W = 26,
  localparam int unsigned WAY_W = sel_w(WAYS),
  localparam int unsigned WRD_W = sel_w(WORDS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [TAG_W-1:0] lk_tag,
  input  logic [WRD_W-1:0] lk_word,
  output logic             hit,
  output logic [31:0]      rdata,
  output logic [WAY_W-1:0] victim,
  input  logic             wr_en,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [WRD_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             commit,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr
);

  // Tag and data need no reset: they are only trusted behind a valid bit.
  typedef struct packed {
    logic [TAG_W-1:0]            tag;
    logic [WORDS-1:0][WORD_W-1:0] data;
  } line_t;

  logic [WAYS-1:0]  valid_q;
  line_t            line_q [WAYS];
  logic [WAY_W-1:0] ptr_q;
  logic [WAY_W-1:0] hit_way;

  // Valid is raised only on the final beat, so a half-filled line never hits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (commit) begin
      valid_q[wr_way] <= 1'b1;
    end
  end

  // Nothing touches this set between victim choice and commit, so
  // valid_q[wr_way] at commit tells whether a live line was evicted.
  generate
    if (WAYS > 1) begin : g_ptr
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          ptr_q <= '0;
        end else if (clr) begin
          ptr_q <= '0;
        end else if (commit && valid_q[wr_way]) begin
          ptr_q <= ptr_q + WAY_W'(1);
        end
      end
    end else begin : g_noptr
      assign ptr_q = '0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (wr_en) line_q[wr_way].data[wr_word] <= wr_data;
    if (commit) line_q[wr_way].tag <= wr_tag;
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w] && (line_q[w].tag == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    rdata = line_q[hit_way].data[lk_word];
  end

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = ptr_q;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[w]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative, multi-word-block, read-only instruction cache.
//   CLK, nRST : clock (rising edge), async active-low reset
//   bus       : icache_assoc_if.slave -- datapath fetch port and memory
//               controller instruction channel
// Hits return in the same cycle. A miss fills the whole block (WORDS beats)
// into the victim way, then the fetch hits on return to IDLE. iflush walks
// every set clearing valid bits, one set per cycle.
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WORDS = 2
) (
  input logic           CLK,
  input logic           nRST,
  icache_assoc_if.slave bus
);

  localparam int unsigned WOFF_B   = off_w(WORDS);
  localparam int unsigned IDX_B    = off_w(SETS);
  localparam int unsigned TAG_W    = tag_w(SETS, WORDS);
  localparam int unsigned WAY_W    = sel_w(WAYS);
  localparam int unsigned WRD_W    = sel_w(WORDS);
  localparam int unsigned IDX_W    = sel_w(SETS);
  localparam logic [31:0] BLK_MASK = 32'(WORDS * 4 - 1);

  function automatic logic [WRD_W-1:0] word_of(input logic [31:0] a);
    return WRD_W'(a >> BYTE_OFF_W) & WRD_W'(WORDS - 1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
    return IDX_W'(a >> (BYTE_OFF_W + WOFF_B));
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return TAG_W'(a >> (BYTE_OFF_W + WOFF_B + IDX_B));
  endfunction

  icache_state_t    state_q, state_d;
  logic [WRD_W-1:0] cnt_q;
  logic             fpend_q;
  logic [IDX_W-1:0] fidx_q;
  logic [31:0]      base_q;
  logic [WAY_W-1:0] victim_q;

  logic             start_fill, fill_we, fill_last, flush_clr;
  logic [IDX_W-1:0] lk_idx, fill_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [WRD_W-1:0] lk_word;

  logic [SETS-1:0]  hit_s;
  logic [31:0]      rdata_s [SETS];
  logic [WAY_W-1:0] vict_s  [SETS];

  assign lk_idx   = idx_of(bus.imemaddr);
  assign lk_tag   = tag_of(bus.imemaddr);
  assign lk_word  = word_of(bus.imemaddr);
  assign fill_idx = idx_of(base_q);

  generate
    for (genvar s = 0; s < SETS; s++) begin : g_set
      icache_assoc_set #(
        .WAYS  (WAYS),
        .WORDS (WORDS),
        .TAG_W (TAG_W)
      ) u_set (
        .CLK     (CLK),
        .nRST    (nRST),
        .lk_tag  (lk_tag),
        .lk_word (lk_word),
        .hit     (hit_s[s]),
        .rdata   (rdata_s[s]),
        .victim  (vict_s[s]),
        .wr_en   (fill_we && (fill_idx == IDX_W'(s))),
        .wr_way  (victim_q),
        .wr_word (cnt_q),
        .wr_data (bus.iload),
        .commit  (fill_last && (fill_idx == IDX_W'(s))),
        .wr_tag  (tag_of(base_q)),
        .clr     (flush_clr && (fidx_q == IDX_W'(s)))
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    start_fill   = 1'b0;
    fill_we      = 1'b0;
    fill_last    = 1'b0;
    flush_clr    = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = bus.imemaddr;
    bus.flushing = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.imemREN && hit_s[lk_idx]) begin
          bus.ihit     = 1'b1;
          bus.imemload = rdata_s[lk_idx];
        end
        // A flush request outranks a simultaneous miss; the fetch simply
        // misses again once the walk is done.
        if (bus.iflush) begin
          state_d = FLUSH;
        end else if (bus.imemREN && !hit_s[lk_idx]) begin
          state_d    = FILL;
          start_fill = 1'b1;
        end
      end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = base_q + 32'({cnt_q, 2'b00});
        if (!bus.iwait) begin
          fill_we = 1'b1;
          if (cnt_q == WRD_W'(WORDS - 1)) begin
            fill_last = 1'b1;
            state_d   = (fpend_q || bus.iflush) ? FLUSH : IDLE;
          end
        end
      end
      FLUSH: begin
        bus.flushing = 1'b1;
        flush_clr    = 1'b1;
        if (fidx_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_fill) begin
        cnt_q <= '0;
      end else if (fill_we) begin
        cnt_q <= cnt_q + WRD_W'(1);
      end
      if (state_q == FILL) begin
        if (fill_last) begin
          fpend_q <= 1'b0;
        end else if (bus.iflush) begin
          fpend_q <= 1'b1;
        end
      end
      // SETS is a power of two, so the walk index wraps back to 0 by itself.
      if (flush_clr) fidx_q <= fidx_q + IDX_W'(1);
    end
  end

  // Fill target, captured on the miss cycle; only consulted during FILL.
  always_ff @(posedge CLK) begin
    if (start_fill) begin
      base_q   <= bus.imemaddr & ~BLK_MASK;
      victim_q <= vict_s[lk_idx];
    end
  end

endmodule
